multicycle_ctrl_unit: RTL and testbench

- Next-generation multicycle RV32I control FSM.
- Sits between the instruction register/decoder and the datapath (PC, register file, ALU, data bus).
- Adds instruction-fetch and data-bus ready handshakes, a parametrised wait-timeout watchdog, and illegal-instruction/bus-timeout traps.
- Adds a retired-instruction counter and fully defined (non-X) outputs in every state.

---
 rtl/multicycle_ctrl_unit.sv | 277 +++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit
//   Multicycle RV32I control FSM sitting between the instruction register /
//   decoder and the datapath. It handles the instruction-fetch and data-bus
//   ready handshakes and runs a wait-state watchdog. It raises traps for
//   illegal instructions and bus/fetch timeouts. It also counts retired
//   instructions.
//
// Ports
//   clk, reset_n        clock (rising edge), async active-low reset
//   instrCode           instruction word, valid from DECODE onwards
//   imemReady/busReady  fetch / data-bus completion handshakes
//   imemReq, instrEn, PCEn, regFileWe, busReq, busWe    datapath strobes
//   aluControl, aluSrcMuxSel, RFWDSrcMuxSel             datapath muxing
//   branch, jal, jalr   PC-select qualifiers
//   func3               load extension select (L_WB only)
//   trap, trapCause     one-cycle trap pulse and its cause
//   instrRetired        one-cycle pulse per completed instruction
//   instret             retired-instruction counter
//
// State is registered. Outputs are decoded combinationally from the state
// and the ready inputs, because a ready handshake must take effect in the
// same cycle it arrives.
module multicycle_ctrl_unit #(
    parameter int unsigned BUS_TIMEOUT  = 15,
    parameter bit          TIMEOUT_EN   = 1'b1,
    parameter int unsigned RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             instrCode,
    input  logic                    imemReady,
    input  logic                    busReady,
    output logic                    imemReq,
    output logic                    instrEn,
    output logic                    PCEn,
    output logic                    regFileWe,
    output logic [3:0]              aluControl,
    output logic                    aluSrcMuxSel,
    output logic                    busReq,
    output logic [1:0]              busWe,
    output logic [2:0]              RFWDSrcMuxSel,
    output logic                    branch,
    output logic                    jal,
    output logic                    jalr,
    output logic [2:0]              func3,
    output logic                    trap,
    output logic [1:0]              trapCause,
    output logic                    instrRetired,
    output logic [RETIRE_CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
        S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_L     = 7'b0000011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;
    localparam logic [1:0] CAUSE_FETCH   = 2'b11;

    // Last tolerated not-ready count; reaching it on a not-ready cycle traps.
    localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic [1:0]              cause_q, cause_d;
    logic [RETIRE_CNT_W-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       timeout_hit;
    logic       wait_stall;

    assign opcode      = instrCode[6:0];
    assign f3          = instrCode[14:12];
    assign timeout_hit = TIMEOUT_EN && (wait_cnt_q == TO_LAST);
    assign instret     = instret_q;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        cause_d       = cause_q;
        wait_stall    = 1'b0;
        imemReq       = 1'b0;
        instrEn       = 1'b0;
        PCEn          = 1'b0;
        regFileWe     = 1'b0;
        aluControl    = 4'b0000;
        aluSrcMuxSel  = 1'b0;
        busReq        = 1'b0;
        busWe         = 2'b00;
        RFWDSrcMuxSel = 3'b000;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        func3         = 3'b000;
        trap          = 1'b0;
        trapCause     = 2'b00;
        instrRetired  = 1'b0;

        case (state_q)
            FETCH: begin
                imemReq = 1'b1;
                if (imemReady) begin
                    instrEn = 1'b1;
                    PCEn    = 1'b1;
                    state_d = DECODE;
                end else if (timeout_hit) begin
                    state_d = TRAP;
                    cause_d = CAUSE_FETCH;
                end else begin
                    wait_stall = 1'b1;
                end
            end
            DECODE: begin
                state_d = TRAP;
                cause_d = CAUSE_ILLEGAL;
                case (opcode)
                    OP_R:     state_d = R_EXE;
                    OP_I:     state_d = I_EXE;
                    OP_B:     state_d = B_EXE;
                    OP_LUI:   state_d = LU_EXE;
                    OP_AUIPC: state_d = AU_EXE;
                    OP_JAL:   state_d = J_EXE;
                    OP_JALR:  state_d = JL_EXE;
                    OP_S:     if (f3 inside {3'b000, 3'b001, 3'b010}) state_d = S_EXE;
                    OP_L:     if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) state_d = L_EXE;
                    default:  state_d = TRAP;
                endcase
            end
            R_EXE: begin
                regFileWe    = 1'b1;
                aluControl   = {instrCode[30], f3};
                instrRetired = 1'b1;
                state_d      = FETCH;
            end
            I_EXE: begin
                regFileWe    = 1'b1;
                aluSrcMuxSel = 1'b1;
                // Only SRLI/SRAI use bit 30 as an opcode bit; elsewhere it is immediate.
                aluControl   = (f3 == 3'b101) ? {instrCode[30], f3} : {1'b0, f3};
                instrRetired = 1'b1;
                state_d      = FETCH;
            end
            B_EXE: begin
                branch       = 1'b1;
                aluControl   = {1'b0, f3};
                instrRetired = 1'b1;
                state_d      = FETCH;
            end
            LU_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b010;
                instrRetired  = 1'b1;
                state_d       = FETCH;
            end
            AU_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b011;
                instrRetired  = 1'b1;
                state_d       = FETCH;
            end
            J_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b100;
                jal           = 1'b1;
                instrRetired  = 1'b1;
                state_d       = FETCH;
            end
            JL_EXE: begin
                regFileWe     = 1'b1;
                RFWDSrcMuxSel = 3'b100;
                jal           = 1'b1;
                jalr          = 1'b1;
                instrRetired  = 1'b1;
                state_d       = FETCH;
            end
            S_EXE: begin
                aluSrcMuxSel = 1'b1;
                state_d      = S_MEM;
            end
            S_MEM: begin
                aluSrcMuxSel = 1'b1;
                busReq       = 1'b1;
                // Store size code is funct3 + 1 for SB/SH/SW.
                busWe        = f3[1:0] + 2'b01;
                if (busReady) begin
                    instrRetired = 1'b1;
                    state_d      = FETCH;
                end else if (timeout_hit) begin
                    state_d = TRAP;
                    cause_d = CAUSE_BUS;
                end else begin
                    wait_stall = 1'b1;
                end
            end
            L_EXE: begin
                aluSrcMuxSel = 1'b1;
                state_d      = L_MEM;
            end
            L_MEM: begin
                aluSrcMuxSel  = 1'b1;
                busReq        = 1'b1;
                RFWDSrcMuxSel = 3'b001;
                if (busReady) begin
                    state_d = L_WB;
                end else if (timeout_hit) begin
                    state_d = TRAP;
                    cause_d = CAUSE_BUS;
                end else begin
                    wait_stall = 1'b1;
                end
            end
            L_WB: begin
                regFileWe     = 1'b1;
                aluSrcMuxSel  = 1'b1;
                RFWDSrcMuxSel = 3'b001;
                func3         = f3;
                instrRetired  = 1'b1;
                state_d       = FETCH;
            end
            TRAP: begin
                trap      = 1'b1;
                PCEn      = 1'b1;
                trapCause = cause_q;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Count only stalled cycles; saturate so an unbounded wait cannot wrap.
        if (state_d != state_q) begin
            wait_cnt_d = 8'd0;
        end else if (wait_stall && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        instret_d = instret_q + {{(RETIRE_CNT_W-1){1'b0}}, instrRetired};

        // Strobes drop asynchronously with reset so a pending store is abandoned at once.
        if (!reset_n) begin
            imemReq      = 1'b0;
            instrEn      = 1'b0;
            PCEn         = 1'b0;
            regFileWe    = 1'b0;
            busReq       = 1'b0;
            busWe        = 2'b00;
            trap         = 1'b0;
            instrRetired = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            wait_cnt_q <= 8'd0;
            cause_q    <= 2'b00;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cause_q    <= cause_d;
            instret_q  <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit (BUS_TIMEOUT=4). Inputs are driven
// at the falling edge and outputs sampled 1ns later, mid-cycle.
module tb_multicycle_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instrCode;
    logic        imemReady, busReady;
    logic        imemReq, instrEn, PCEn, regFileWe, aluSrcMuxSel, busReq;
    logic [3:0]  aluControl;
    logic [1:0]  busWe, trapCause;
    logic [2:0]  RFWDSrcMuxSel, func3;
    logic        branch, jal, jalr, trap, instrRetired;
    logic [31:0] instret;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_instret = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_unit #(.BUS_TIMEOUT(4), .TIMEOUT_EN(1'b1), .RETIRE_CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .instrCode(instrCode),
        .imemReady(imemReady), .busReady(busReady),
        .imemReq(imemReq), .instrEn(instrEn), .PCEn(PCEn), .regFileWe(regFileWe),
        .aluControl(aluControl), .aluSrcMuxSel(aluSrcMuxSel), .busReq(busReq),
        .busWe(busWe), .RFWDSrcMuxSel(RFWDSrcMuxSel), .branch(branch), .jal(jal),
        .jalr(jalr), .func3(func3), .trap(trap), .trapCause(trapCause),
        .instrRetired(instrRetired), .instret(instret)
    );

    task automatic nxt();
        @(negedge clk);
    endtask

    // FETCH with imemReady then DECODE; leaves the bench inside the DECODE cycle.
    task automatic fetch_decode(input logic [31:0] code);
        nxt(); instrCode = code; imemReady = 1'b1;
        nxt(); imemReady = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; instrCode = 32'h0; imemReady = 1'b0; busReady = 1'b0;
        nxt(); nxt(); #1;
        n_chk++;
        if ({imemReq, instrEn, PCEn, regFileWe, busReq, busWe, trap, instrRetired} !== 9'b0) begin
            n_fail++; $display("FAIL reset_strobes got %b exp 0",
                {imemReq, instrEn, PCEn, regFileWe, busReq, busWe, trap, instrRetired});
        end
        n_chk++;
        if ({aluControl, instret} !== 36'h0) begin
            n_fail++; $display("FAIL reset_alu_instret got alu=%h instret=%0d exp 0/0", aluControl, instret);
        end
        reset_n = 1'b1; #1;
        n_chk++;
        if ({imemReq, instrEn} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release_fetch got %b exp 10", {imemReq, instrEn});
        end
    endtask

    task automatic test_add();
        nxt(); instrCode = 32'h002081B3; imemReady = 1'b1; #1;
        n_chk++;
        if ({imemReq, instrEn, PCEn} !== 3'b111) begin
            n_fail++; $display("FAIL add_fetch got %b exp 111", {imemReq, instrEn, PCEn});
        end
        nxt(); imemReady = 1'b0; #1;
        n_chk++;
        if ({imemReq, instrEn, PCEn, regFileWe, instrRetired} !== 5'b0) begin
            n_fail++; $display("FAIL add_decode got %b exp 0", {imemReq, instrEn, PCEn, regFileWe, instrRetired});
        end
        nxt(); #1;
        n_chk++;
        if ({regFileWe, aluControl, aluSrcMuxSel, instrRetired} !== 7'b1_0000_0_1) begin
            n_fail++; $display("FAIL add_rexe got %b exp 1000001", {regFileWe, aluControl, aluSrcMuxSel, instrRetired});
        end
        exp_instret++;
        nxt(); #1;
        n_chk++;
        if (instret !== exp_instret || imemReq !== 1'b1) begin
            n_fail++; $display("FAIL add_instret got %0d req=%b exp %0d req=1", instret, imemReq, exp_instret);
        end
    endtask

    task automatic test_alu_branch_jump();
        fetch_decode(32'h4030D193);   // SRAI x3,x1,3
        nxt(); #1;
        n_chk++;
        if ({regFileWe, aluSrcMuxSel, aluControl, instrRetired} !== 7'b1_1_1101_1) begin
            n_fail++; $display("FAIL srai got %b exp 1111011", {regFileWe, aluSrcMuxSel, aluControl, instrRetired});
        end
        exp_instret++;
        fetch_decode(32'h40208463);   // BEQ, bit 30 is immediate
        nxt(); #1;
        n_chk++;
        if ({branch, aluControl, regFileWe, aluSrcMuxSel, instrRetired} !== 8'b1_0000_0_0_1) begin
            n_fail++; $display("FAIL beq got %b exp 10000001", {branch, aluControl, regFileWe, aluSrcMuxSel, instrRetired});
        end
        exp_instret++;
        fetch_decode(32'h000010B7);   // LUI
        nxt(); #1;
        n_chk++;
        if ({regFileWe, RFWDSrcMuxSel, jal, jalr} !== 6'b1_010_0_0) begin
            n_fail++; $display("FAIL lui got %b exp 101000", {regFileWe, RFWDSrcMuxSel, jal, jalr});
        end
        exp_instret++;
        fetch_decode(32'h000080E7);   // JALR x1,0(x1)
        nxt(); #1;
        n_chk++;
        if ({regFileWe, RFWDSrcMuxSel, jal, jalr, instrRetired} !== 7'b1_100_1_1_1) begin
            n_fail++; $display("FAIL jalr got %b exp 1100111", {regFileWe, RFWDSrcMuxSel, jal, jalr, instrRetired});
        end
        exp_instret++;
    endtask

    task automatic test_store();
        fetch_decode(32'h0020A023);   // SW
        nxt(); #1;
        n_chk++;
        if ({aluSrcMuxSel, busReq, instrRetired} !== 3'b100) begin
            n_fail++; $display("FAIL sw_exe got %b exp 100", {aluSrcMuxSel, busReq, instrRetired});
        end
        for (int i = 0; i < 4; i++) begin
            nxt(); busReady = (i == 3); #1;
            n_chk++;
            if ({busReq, busWe, aluSrcMuxSel, regFileWe, instrRetired} !== {4'b1_11_1, 1'b0, (i == 3)}) begin
                n_fail++; $display("FAIL sw_mem[%0d] got %b exp %b", i,
                    {busReq, busWe, aluSrcMuxSel, regFileWe, instrRetired}, {4'b1_11_1, 1'b0, (i == 3)});
            end
        end
        exp_instret++;
        nxt(); busReady = 1'b0; #1;
        n_chk++;
        if (instret !== exp_instret || {imemReq, busReq} !== 2'b10) begin
            n_fail++; $display("FAIL sw_retire got %0d %b exp %0d 10", instret, {imemReq, busReq}, exp_instret);
        end
    endtask

    task automatic test_load();
        busReady = 1'b1;
        fetch_decode(32'h00109183);   // LH
        nxt(); #1;
        n_chk++;
        if ({aluSrcMuxSel, busReq} !== 2'b10) begin
            n_fail++; $display("FAIL lh_exe got %b exp 10", {aluSrcMuxSel, busReq});
        end
        nxt(); #1;
        n_chk++;
        if ({busReq, busWe, RFWDSrcMuxSel, regFileWe, instrRetired} !== 8'b1_00_001_0_0) begin
            n_fail++; $display("FAIL lh_mem got %b exp 10000100", {busReq, busWe, RFWDSrcMuxSel, regFileWe, instrRetired});
        end
        nxt(); #1;
        n_chk++;
        if ({regFileWe, func3, RFWDSrcMuxSel, busReq, instrRetired} !== 9'b1_001_001_0_1) begin
            n_fail++; $display("FAIL lh_wb got %b exp 100100101", {regFileWe, func3, RFWDSrcMuxSel, busReq, instrRetired});
        end
        exp_instret++;
        busReady = 1'b0;
        nxt(); #1;
        n_chk++;
        if (instret !== exp_instret || func3 !== 3'b000) begin
            n_fail++; $display("FAIL lh_retire got %0d f3=%b exp %0d 000", instret, func3, exp_instret);
        end
    endtask

    task automatic test_illegal();
        fetch_decode(32'h0000007F);
        #1;
        n_chk++;
        if (trap !== 1'b0) begin
            n_fail++; $display("FAIL ill_decode_trap got %b exp 0", trap);
        end
        nxt(); #1;
        n_chk++;
        if ({trap, trapCause, PCEn, regFileWe, busReq, instrRetired} !== 7'b1_01_1_0_0_0) begin
            n_fail++; $display("FAIL ill_trap got %b exp 1011000", {trap, trapCause, PCEn, regFileWe, busReq, instrRetired});
        end
        fetch_decode(32'h0020B023);   // store with funct3=011
        nxt(); #1;
        n_chk++;
        if ({trap, trapCause, busReq} !== 4'b1_01_0) begin
            n_fail++; $display("FAIL ill_store_f3 got %b exp 1010", {trap, trapCause, busReq});
        end
        nxt(); #1;
        n_chk++;
        if (instret !== exp_instret || {trap, trapCause, imemReq} !== 4'b0_00_1) begin
            n_fail++; $display("FAIL ill_instret got %0d %b exp %0d 0001", instret, {trap, trapCause, imemReq}, exp_instret);
        end
    endtask

    task automatic test_timeouts();
        // Load never completes: 4 stalled L_MEM cycles, then bus-timeout trap.
        fetch_decode(32'h0000A183);   // LW
        nxt();                        // L_EXE
        for (int i = 0; i < 4; i++) begin
            nxt(); #1;
            n_chk++;
            if ({busReq, trap} !== 2'b10) begin
                n_fail++; $display("FAIL lw_to_wait[%0d] got %b exp 10", i, {busReq, trap});
            end
        end
        nxt(); #1;
        n_chk++;
        if ({trap, trapCause, PCEn, regFileWe, instrRetired, busReq} !== 7'b1_10_1_0_0_0) begin
            n_fail++; $display("FAIL lw_to_trap got %b exp 1101000", {trap, trapCause, PCEn, regFileWe, instrRetired, busReq});
        end
        // Ready on the final tolerated cycle beats the watchdog.
        fetch_decode(32'h0000A183);
        nxt();
        for (int i = 0; i < 4; i++) begin
            nxt(); busReady = (i == 3);
        end
        nxt(); busReady = 1'b0; #1;
        n_chk++;
        if ({trap, regFileWe, func3, instrRetired} !== 6'b0_1_010_1) begin
            n_fail++; $display("FAIL lw_ready_wins got %b exp 010101", {trap, regFileWe, func3, instrRetired});
        end
        exp_instret++;
        // Fetch never returns: 4 stalled FETCH cycles, then cause 11.
        for (int i = 0; i < 4; i++) begin
            nxt(); #1;
            n_chk++;
            if ({imemReq, trap} !== 2'b10) begin
                n_fail++; $display("FAIL fetch_to_wait[%0d] got %b exp 10", i, {imemReq, trap});
            end
        end
        nxt(); #1;
        n_chk++;
        if ({trap, trapCause, PCEn, imemReq} !== 5'b1_11_1_0) begin
            n_fail++; $display("FAIL fetch_to_trap got %b exp 11110", {trap, trapCause, PCEn, imemReq});
        end
        nxt(); #1;
        n_chk++;
        if (instret !== exp_instret) begin
            n_fail++; $display("FAIL to_instret got %0d exp %0d", instret, exp_instret);
        end
    endtask

    task automatic test_reset_mid_store();
        fetch_decode(32'h00209023);   // SH
        nxt();                        // S_EXE
        nxt(); #1;
        n_chk++;
        if ({busReq, busWe} !== 3'b1_10) begin
            n_fail++; $display("FAIL sh_mem got %b exp 110", {busReq, busWe});
        end
        reset_n = 1'b0; #1;
        n_chk++;
        if ({busReq, busWe, instrRetired} !== 4'b0 || instret !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset got %b instret=%0d exp 0000 0", {busReq, busWe, instrRetired}, instret);
        end
        exp_instret = 0;
        nxt(); reset_n = 1'b1; #1;
        n_chk++;
        if ({imemReq, busReq, instrEn} !== 3'b100 || instret !== exp_instret) begin
            n_fail++; $display("FAIL post_reset got %b instret=%0d exp 100 0", {imemReq, busReq, instrEn}, instret);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_branch_jump();
        test_store();
        test_load();
        test_illegal();
        test_timeouts();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
